// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the instruction-fetch sequencer.
//   - default trap / interrupt vectors and ROM depth
//   - redir_sel encodings used by decode
//   - fetch FSM state encodings
package fetch_ctrl_pkg;

  localparam logic [31:0] DEF_RESET_ADDR = 32'd0;
  localparam logic [31:0] DEF_ILLOP_ADDR = 32'd504;
  localparam logic [31:0] DEF_XADR_ADDR  = 32'd508;
  localparam int unsigned DEF_IMEM_WORDS = 128;

  localparam logic [1:0] REDIR_BRANCH = 2'd0;
  localparam logic [1:0] REDIR_JMP    = 2'd1;
  localparam logic [1:0] REDIR_ILLOP  = 2'd2;
  localparam logic [1:0] REDIR_RSVD   = 2'd3;

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STALL  = 2'd2;
  localparam logic [1:0] ST_SQUASH = 2'd3;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux for fetch_ctrl (purely combinational).
// Ports:
//   pc_i           current program counter
//   load_i         a fetch would load ir this cycle
//   live_i         ir holds a live instruction (redirects only act on one)
//   irq_req_i      an interrupt is pending at an accept
//   redir_valid_i  decode redirect request
//   redir_sel_i    redirect kind
//   redir_target_i branch / JMP target
//   next_pc_o      PC for the next cycle
//   trap_o         a trap (bad fetch, illop, interrupt) is taken
//   bad_fetch_o    the trap is a bad fetch (xp value derives from pc)
//   irq_taken_o    the interrupt won arbitration
//   squash_o       control flow changes; the next cycle is a bubble
module fetch_next_pc
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] ILLOP_ADDR = DEF_ILLOP_ADDR,
  parameter logic [31:0] XADR_ADDR  = DEF_XADR_ADDR,
  parameter int unsigned IMEM_WORDS = DEF_IMEM_WORDS
) (
  input  logic [31:0] pc_i,
  input  logic        load_i,
  input  logic        live_i,
  input  logic        irq_req_i,
  input  logic        redir_valid_i,
  input  logic [1:0]  redir_sel_i,
  input  logic [31:0] redir_target_i,
  output logic [31:0] next_pc_o,
  output logic        trap_o,
  output logic        bad_fetch_o,
  output logic        irq_taken_o,
  output logic        squash_o
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);

  logic bad, illop, jump;
  logic tgt_lsb_unused;

  assign tgt_lsb_unused = ^redir_target_i[1:0];

  assign bad   = load_i & (pc_i >= IMEM_LIMIT);
  assign illop = live_i & redir_valid_i &
                 ((redir_sel_i == REDIR_ILLOP) | (redir_sel_i == REDIR_RSVD));
  assign jump  = live_i & redir_valid_i &
                 ((redir_sel_i == REDIR_BRANCH) | (redir_sel_i == REDIR_JMP));

  always_comb begin
    next_pc_o   = pc_i;
    trap_o      = 1'b0;
    irq_taken_o = 1'b0;
    squash_o    = 1'b0;
    if (bad) begin
      next_pc_o = ILLOP_ADDR;
      trap_o    = 1'b1;
      squash_o  = 1'b1;
    end else if (illop) begin
      next_pc_o = ILLOP_ADDR;
      trap_o    = 1'b1;
      squash_o  = 1'b1;
    end else if (irq_req_i) begin
      next_pc_o   = XADR_ADDR;
      trap_o      = 1'b1;
      irq_taken_o = 1'b1;
      squash_o    = 1'b1;
    end else if (jump) begin
      next_pc_o = {redir_target_i[31:2], 2'b00};
      squash_o  = 1'b1;
    end else if (load_i) begin
      next_pc_o = pc_i + 32'd4;
    end
  end

  assign bad_fetch_o = bad;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC driving the instruction ROM,
// registers the returned word into ir, hands it to decode over
// ir_valid/ir_ready, applies branch/JMP/trap redirects and writes r30.
// Optional feature macro: FETCH_IRQ_EN (interrupt pending flag and vector).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   pc / id               ROM address out, ROM data in (same cycle)
//   ir, ir_pc, ir_valid   registered instruction, its address, live flag
//   ir_ready              decode accepts ir this cycle
//   redir_valid/sel/target decode redirect request
//   irq                   level interrupt request
//   xp_we, xp_data        r30 write port
//   instr_count           accepted-instruction counter
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEF_RESET_ADDR,
  parameter logic [31:0] ILLOP_ADDR = DEF_ILLOP_ADDR,
  parameter logic [31:0] XADR_ADDR  = DEF_XADR_ADDR,
  parameter int unsigned IMEM_WORDS = DEF_IMEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] id,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redir_valid,
  input  logic [1:0]  redir_sel,
  input  logic [31:0] redir_target,
  input  logic        irq,
  output logic        xp_we,
  output logic [31:0] xp_data,
  output logic [31:0] instr_count
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        xp_we_q, xp_we_d;
  logic [31:0] xp_data_q, xp_data_d;
  logic [31:0] cnt_q, cnt_d;

  logic accept, load, irq_req, irq_taken;
  logic trap, bad_fetch, squash;

  assign accept = ir_valid_q & ir_ready;
  // BOOT never loads; otherwise load whenever ir is empty or being consumed.
  assign load   = (state_q != ST_BOOT) & (~ir_valid_q | ir_ready);

`ifdef FETCH_IRQ_EN
  logic irq_pend_q, irq_pend_d;
  // The current-cycle level counts as pending so an irq coincident with an
  // accept is taken on that accept.
  assign irq_req    = (irq_pend_q | irq) & accept;
  assign irq_pend_d = (irq_pend_q | irq) & ~irq_taken;

  always_ff @(posedge clk) begin
    if (reset) irq_pend_q <= 1'b0;
    else       irq_pend_q <= irq_pend_d;
  end
`else
  logic irq_unused;
  logic irq_taken_unused;
  assign irq_unused       = irq;
  assign irq_taken_unused = irq_taken;
  assign irq_req          = 1'b0;
`endif

  fetch_next_pc #(
    .ILLOP_ADDR (ILLOP_ADDR),
    .XADR_ADDR  (XADR_ADDR),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_next_pc (
    .pc_i           (pc_q),
    .load_i         (load),
    .live_i         (ir_valid_q),
    .irq_req_i      (irq_req),
    .redir_valid_i  (redir_valid),
    .redir_sel_i    (redir_sel),
    .redir_target_i (redir_target),
    .next_pc_o      (pc_d),
    .trap_o         (trap),
    .bad_fetch_o    (bad_fetch),
    .irq_taken_o    (irq_taken),
    .squash_o       (squash)
  );

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    xp_we_d    = 1'b0;
    xp_data_d  = xp_data_q;
    cnt_d      = accept ? cnt_q + 32'd1 : cnt_q;
    if (state_q == ST_BOOT) begin
      state_d = ST_RUN;
    end else if (squash) begin
      // Redirect or trap: drop the wrong-path word, bubble one cycle.
      state_d    = ST_SQUASH;
      ir_valid_d = 1'b0;
      if (trap) begin
        xp_we_d   = 1'b1;
        xp_data_d = bad_fetch ? pc_q + 32'd4 : ir_pc_q + 32'd4;
      end
    end else if (load) begin
      state_d    = ST_RUN;
      ir_d       = id;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
    end else begin
      state_d = ST_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_ADDR;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      xp_we_q    <= 1'b0;
      xp_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      xp_we_q    <= xp_we_d;
      xp_data_q  <= xp_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign xp_we       = xp_we_q;
  assign xp_data     = xp_data_q;
  assign instr_count = cnt_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the RISC core. It owns the program counter that addresses the combinational instruction ROM (`instr`) and registers the returned word into an instruction register. It presents that register to decode over a valid/ready handshake. It applies branch, jump and trap redirects, and writes the exception pointer (r30) on traps.

## Interface
Parameters:
- `RESET_ADDR`, default 32'd0: PC after reset; the program selector lives here.
- `ILLOP_ADDR`, default 32'd504: illegal-op / bad-fetch trap vector.
- `XADR_ADDR`, default 32'd508: interrupt vector.
- `IMEM_WORDS`, default 128: ROM depth in words. Legal PC is below IMEM_WORDS*4.

Ports:
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `pc`, out, 32: address to `instr`.
- `id`, in, 32: ROM data for `pc`, available in the same cycle.
- `ir`, out, 32: registered instruction.
- `ir_pc`, out, 32: address `ir` was fetched from.
- `ir_valid`, out, 1: `ir` holds a live instruction.
- `ir_ready`, in, 1: decode accepts `ir` this cycle.
- `redir_valid`, in, 1: decode requests a redirect.
- `redir_sel`, in, 2: 0 = branch, 1 = JMP, 2 = illop, 3 = reserved (treated as illop).
- `redir_target`, in, 32: target address for branch or JMP.
- `irq`, in, 1: level interrupt request.
- `xp_we`, out, 1: write enable for r30.
- `xp_data`, out, 32: value to write to r30.
- `instr_count`, out, 32: count of accepted instructions.

## Operation
- States: BOOT, RUN, STALL, SQUASH.
- Reset, in any state and mid-operation:
  - state ← BOOT, `pc` ← RESET_ADDR.
  - `ir` ← 0, `ir_pc` ← 0, `ir_valid` ← 0.
  - `xp_we` ← 0, `xp_data` ← 0, `instr_count` ← 0, irq pending flag ← 0.
- BOOT: one cycle with `ir_valid` = 0, then go to RUN. No fetch is loaded during this cycle.
- Fetch: when `ir` is empty or consumed, the edge loads `ir` ← `id` and `ir_pc` ← `pc`, then `pc` ← `pc` + 4 and `ir_valid` ← 1.
- STALL: entered when `ir_valid` & !`ir_ready`. `pc`, `ir` and `ir_pc` hold. Return to RUN on the edge where `ir_ready` = 1.
- Accept: `ir_valid` & `ir_ready` increments `instr_count`, wrapping modulo 2^32.
- Next-PC priority, highest first:
  1. reset
  2. bad fetch
  3. `redir_valid` with `redir_sel` ≥ 2
  4. pending irq at an accept
  5. `redir_valid` with branch or JMP
  6. hold
  7. sequential fetch
- Branch/JMP: `pc` ← {`redir_target`[31:2], 2'b00}, then go to SQUASH. A redirect dominates STALL.
- Illop redirect:
  - `pc` ← ILLOP_ADDR.
  - `xp_we` pulses for one cycle with `xp_data` = `ir_pc` + 4.
  - Go to SQUASH.
- Bad fetch: `pc` ≥ IMEM_WORDS*4 in RUN, on a cycle where a fetch would load.
  - `id` is not loaded.
  - `pc` ← ILLOP_ADDR, `xp_we` pulses with `xp_data` = `pc` + 4.
  - Go to SQUASH.
- SQUASH: one cycle with `ir_valid` = 0. The wrong-path word is discarded. The target word loads on the next edge, then go to RUN.
- Simultaneous irq and branch on one accept: irq wins. `xp_data` = `ir_pc` + 4 and the branch is dropped.
- Arithmetic: all PC math is 32-bit and wraps; there is no carry-out. `pc`[1:0] is always 00.

## Timing
- Redirect requested in cycle N: `pc` = target in N+1, `ir_valid` = 0 in N+1, target instruction valid in N+2. The penalty is one bubble.
- `xp_we` is asserted only in the cycle after the trap decision.
- Sequential throughput is one instruction per cycle while `ir_ready` = 1.
- After `reset` falls, the first valid `ir` (word at RESET_ADDR) appears 2 cycles later.

## Configuration
- `FETCH_IRQ_EN` defined:
  - `irq` is sampled every cycle into a pending flag.
  - The flag is taken at the next accept: `pc` ← XADR_ADDR, `xp_we` pulses with `xp_data` = `ir_pc` + 4, and the state goes to SQUASH.
  - The pending flag clears when the interrupt is taken.
- Undefined: `irq` is ignored, the pending flag and its logic are absent, and XADR_ADDR is never produced.

## Structure
- Put the vector defaults, `redir_sel` encodings and state encodings in the shared `risc_constants.vh` header. `instr` already includes this header.
- Sub-module `fetch_next_pc`: combinational priority mux producing the next PC and a trap flag. The state register, `ir`, `instr_count` and the XP logic stay in `fetch_ctrl`.

## Test plan
- Reset behaviour: release `reset` → `pc` = 0 and `ir_valid` = 0 for 2 cycles; then `ir_pc` = 0 and `pc` = 4 with `ir_valid` = 1, and `instr_count` increments once per cycle while `ir_ready` = 1.
- Stall: hold `ir_ready` = 0 for 3 cycles at `ir_pc` = 8 → `pc` stays 12, `ir` stays stable and `instr_count` is frozen; release → `ir_pc` = 12 next.
- Branch: `redir_valid`, `redir_sel` = 0, `redir_target` = 80 while `ir_ready` = 0 → `pc` = 80, one bubble, then `ir_pc` = 80 with `ir` = ROM word 20.
- Bad fetch: run sequentially to `pc` = 512 → `pc` = 504, `xp_we` = 1 for one cycle with `xp_data` = 516, and no word from 512 reaches `ir`.
- Illop redirect: `redir_sel` = 2 with `ir_pc` = 36 → `xp_data` = 40 and `pc` = 504.
- Interrupt (`FETCH_IRQ_EN`): `irq` pulse plus a simultaneous branch on an accept with `ir_pc` = 100 → `pc` = 508, `xp_data` = 104, branch ignored. Without the macro, the same stimulus leaves the branch taken.
